tile_grid_vga: RTL
==================

Name: tile_grid_vga

Overview:
- Parametrised successor to the playfield VGA controller: generates 640x480 VGA timing internally and renders a GRID_COLS x GRID_ROWS tile playfield with 2-bit cell types.
- Each cell type maps to its own colour. A border ring surrounds the playfield. Pixels outside the playfield and border show a background colour.
- Single clock domain: the processor writes cells on iVGA_CLK through a strobe port, and a self-timed clear sweep is available.
- Sits between the game-logic processor and the board VGA DAC.

Parameters:
- GRID_COLS, 10, playfield columns.
- GRID_ROWS, 20, playfield rows.
- TILE_PX, 20, tile edge in pixels (square tiles).
- ORG_X, 100, playfield left pixel column.
- ORG_Y, 40, playfield top pixel row.
- BORDER_PX, 4, border ring thickness outside the playfield; 0 disables the border.
- IDX_W, 8, cell index width; must satisfy 2^IDX_W >= GRID_COLS*GRID_ROWS.
- H_ACT/H_FP/H_SYN/H_BP, 640/16/96/48, horizontal timing in pixels.
- V_ACT/V_FP/V_SYN/V_BP, 480/10/2/33, vertical timing in lines.
- COL_BG/COL_BRD/COL_T1/COL_T2/COL_T3, 24'h000000/24'h808080/24'hFFFFFF/24'h0000FF/24'h404040, RGB for background/border/type 01/10/11.

Ports:
- iVGA_CLK  in  1  pixel clock; the only clock.
- iRST  in  1  asynchronous, active-high reset.
- iWR_EN  in  1  cell write strobe; one write per cycle.
- iWR_IDX  in  IDX_W  cell index = row*GRID_COLS + col.
- iWR_TYPE  in  2  cell type: 00 empty, 01 falling, 10 stuck, 11 ghost.
- iCLR_REQ  in  1  one-cycle pulse starting a clear sweep.
- oCLR_BUSY  out  1  high while the sweep runs.
- oFRAME_START  out  1  one-cycle pulse, aligned with the first active pixel of a frame.
- oHS  out  1  horizontal sync, active low.
- oVS  out  1  vertical sync, active low.
- oBLANK_n  out  1  high during active video.
- oR, oG, oB  out  8 each  pixel colour.

Behaviour:
- Reset (asynchronous, while iRST=1):
  - h/v counters = 0; all cells = 00; sweep idle.
  - oCLR_BUSY=0, oFRAME_START=0, oHS=1, oVS=1, oBLANK_n=0, RGB=0.
  - Reset asserted mid-frame or mid-sweep aborts both immediately. After release, scanning restarts at h=0, v=0.
- Timing counters:
  - h counts 0..H_TOT-1, where H_TOT = H_ACT+H_FP+H_SYN+H_BP. v increments when h wraps, over 0..V_TOT-1; both wrap to 0 at the end of the frame.
  - Raw sync: hs_raw=0 for h in [H_ACT+H_FP, H_ACT+H_FP+H_SYN); vs_raw likewise on v.
  - Raw blank: blank_n_raw = (h<H_ACT && v<V_ACT).
- Pixel pipeline, fixed latency of 2 cycles:
  - S0: counters.
  - S1: registered tile column/row plus an in-playfield flag and an in-border flag. Tile column/row come from tile sub-counters (increment every TILE_PX pixels); no dividers.
  - S2: cell read, palette lookup, registered outputs.
- Output alignment:
  - oHS, oVS and oBLANK_n are the raw values delayed 2 cycles, so they align with RGB.
  - RGB=0 whenever the aligned oBLANK_n=0.
- Colour select, in priority order:
  1. Inside the playfield: the type palette colour; type 00 gives COL_BG.
  2. Else inside the border ring: COL_BRD.
  3. Else: COL_BG.
- Playfield region: x in [ORG_X, ORG_X+GRID_COLS*TILE_PX), y in [ORG_Y, ORG_Y+GRID_ROWS*TILE_PX).
- Cell storage: GRID_COLS*GRID_ROWS x 2-bit register array.
- Writes:
  - Committed at the clock edge when iWR_EN=1, iWR_IDX < CELLS and oCLR_BUSY=0.
  - An out-of-range index is ignored.
  - A write and an S2 read of the same cell in the same cycle: the pixel shows the old value. The new value shows from the next cycle.
  - No frame buffering: mid-frame updates may tear.
- Clear sweep:
  - iCLR_REQ=1 while idle sets oCLR_BUSY=1 on the next edge.
  - Each busy cycle writes 00 to the cell at sweep index k, for k = 0..CELLS-1.
  - oCLR_BUSY falls on the edge after k=CELLS-1 is written. Busy lasts exactly CELLS cycles.
  - While busy, iWR_EN and iCLR_REQ are ignored.
  - iCLR_REQ and iWR_EN in the same idle cycle: the write is committed, then the sweep starts, so that cell ends as 00.
- oFRAME_START: high for exactly one cycle when the aligned output shows h=0, v=0.

Test Plan:
- Reset release, free run 2 frames:
  - oFRAME_START period = 800*525 = 420000 cycles.
  - oHS low for 96 cycles per line, starting 656 cycles after the line start.
  - oVS low for 2 lines starting at line 490.
  - oBLANK_n high for 640 cycles per line on lines 0..479.
  - RGB=0 during blank.
- Cell write and readout:
  - Write idx 0 = 01, idx 199 = 10.
  - Pixel (100,40) = FFFFFF; pixel (299,439) = 0000FF; pixel (120,40) = 000000.
  - Border pixel (97,40) = 808080; pixel (50,50) = 000000.
- Latency: force cell 0 = 11. RGB changes to 404040 exactly 2 cycles after S0 reaches h=100, v=40, aligned with oBLANK_n.
- Write the same cell in the same cycle it is displayed: that pixel shows the old colour, and the adjacent pixel in the same tile shows the new colour.
- Clear sweep:
  - Fill all cells with 10, then pulse iCLR_REQ. oCLR_BUSY is high for exactly 200 cycles.
  - An iWR_EN to idx 5 during the sweep has no effect; all cells read back 00.
  - A second iCLR_REQ while busy does not extend busy.
- iWR_IDX=200 (out of range) with iWR_EN=1: no cell changes. Assert iRST mid-sweep: oCLR_BUSY=0 and all cells 00 immediately.

Source files
------------

// File: rtl/tile_grid_vga_if.sv
// ---------------------------------------------------------------------------
// tile_grid_vga_if
// Processor-side bus of the tile playfield VGA controller. It carries the
// cell write strobe, the clear-sweep request and the sweep busy flag.
//   iWR_EN    : cell write strobe, one write per cycle
//   iWR_IDX   : cell index = row*GRID_COLS + col
//   iWR_TYPE  : 2-bit cell type (00 empty, 01 falling, 10 stuck, 11 ghost)
//   iCLR_REQ  : one-cycle pulse that starts a clear sweep
//   oCLR_BUSY : high while the clear sweep runs
// The master modport is the game-logic processor; the slave is the controller.
// ---------------------------------------------------------------------------
interface tile_grid_vga_if #(
  parameter int IDX_W = 8
);
  logic             iWR_EN;
  logic [IDX_W-1:0] iWR_IDX;
  logic [1:0]       iWR_TYPE;
  logic             iCLR_REQ;
  logic             oCLR_BUSY;

  modport master (
    output iWR_EN, iWR_IDX, iWR_TYPE, iCLR_REQ,
    input  oCLR_BUSY
  );

  modport slave (
    input  iWR_EN, iWR_IDX, iWR_TYPE, iCLR_REQ,
    output oCLR_BUSY
  );
endinterface

// File: rtl/tile_grid_vga.sv
// ---------------------------------------------------------------------------
// tile_grid_vga
// Generates VGA timing and renders a GRID_COLS x GRID_ROWS playfield of 2-bit
// cells, surrounded by a border ring, on a background colour.
// Pixel pipeline: S0 counters -> S1 tile coordinates/region flags ->
// S2 cell read, palette, registered outputs (2-cycle latency, syncs aligned).
// Ports:
//   iVGA_CLK     : pixel clock, the only clock
//   iRST         : asynchronous active-high reset
//   cpu_bus      : processor bus (cell writes, clear sweep request/busy)
//   oFRAME_START : one-cycle pulse with the first active pixel of a frame
//   oHS, oVS     : active-low syncs
//   oBLANK_n     : high during active video
//   oR, oG, oB   : pixel colour
// ---------------------------------------------------------------------------
module tile_grid_vga #(
  parameter int          GRID_COLS = 10,
  parameter int          GRID_ROWS = 20,
  parameter int          TILE_PX   = 20,
  parameter int          ORG_X     = 100,
  parameter int          ORG_Y     = 40,
  parameter int          BORDER_PX = 4,
  parameter int          IDX_W     = 8,
  parameter int          H_ACT     = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYN     = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACT     = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYN     = 2,
  parameter int          V_BP      = 33,
  parameter logic [23:0] COL_BG    = 24'h000000,
  parameter logic [23:0] COL_BRD   = 24'h808080,
  parameter logic [23:0] COL_T1    = 24'hFFFFFF,
  parameter logic [23:0] COL_T2    = 24'h0000FF,
  parameter logic [23:0] COL_T3    = 24'h404040
) (
  input  logic                  iVGA_CLK,
  input  logic                  iRST,
  tile_grid_vga_if.slave        cpu_bus,
  output logic                  oFRAME_START,
  output logic                  oHS,
  output logic                  oVS,
  output logic                  oBLANK_n,
  output logic [7:0]            oR,
  output logic [7:0]            oG,
  output logic [7:0]            oB
);

  localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int TPW   = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
  localparam int CELLS = GRID_COLS * GRID_ROWS;
  localparam int CIW   = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int PF_X1 = ORG_X + GRID_COLS * TILE_PX;
  localparam int PF_Y1 = ORG_Y + GRID_ROWS * TILE_PX;
  localparam int BR_X0 = ORG_X - BORDER_PX;
  localparam int BR_X1 = PF_X1 + BORDER_PX;
  localparam int BR_Y0 = ORG_Y - BORDER_PX;
  localparam int BR_Y1 = PF_Y1 + BORDER_PX;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_t;

  // S0 state: raster position plus tile coordinate sub-counters
  logic [HW-1:0]  r_h;
  logic [VW-1:0]  r_v;
  logic [HW-1:0]  r_tcol;
  logic [TPW-1:0] r_tpx;
  logic [VW-1:0]  r_trow;
  logic [TPW-1:0] r_tpy;

  logic           w_h_end;
  logic           w_v_end;
  logic [HW-1:0]  w_h_nxt;
  logic [VW-1:0]  w_v_nxt;
  int             w_x;
  int             w_y;
  logic           w_in_pf;
  logic           w_in_brd;
  logic           w_hs_raw;
  logic           w_vs_raw;
  logic           w_blank_n_raw;
  logic           w_fs_raw;

  // S1 registers
  logic [HW-1:0]  r_s1_tcol;
  logic [VW-1:0]  r_s1_trow;
  logic           r_s1_in_pf;
  logic           r_s1_in_brd;
  logic           r_s1_hs;
  logic           r_s1_vs;
  logic           r_s1_blank_n;
  logic           r_s1_fs;

  // S2 read/palette
  int             w_idx_full;
  logic [CIW-1:0] w_cell_idx;
  logic [1:0]     w_cell;
  logic [23:0]    w_rgb;

  // Output registers
  logic [23:0]    r_rgb;
  logic           r_hs;
  logic           r_vs;
  logic           r_blank_n;
  logic           r_fs;

  // Cell storage and clear sweep
  logic [1:0]     r_cells [CELLS];
  sweep_state_t   r_state;
  sweep_state_t   w_state_nxt;
  logic [CIW-1:0] r_k;
  logic [CIW-1:0] w_k_nxt;
  logic           w_wr_ok;
  logic [CIW-1:0] w_wr_idx;

  // Next raster position, wrap detection and raw sync/blank/region decode
  always_comb begin
    w_h_end       = (r_h == HW'(H_TOT - 1));
    w_v_end       = (r_v == VW'(V_TOT - 1));
    w_h_nxt       = w_h_end ? HW'(0) : r_h + 1'b1;
    w_v_nxt       = r_v;
    if (w_h_end) begin
      w_v_nxt = w_v_end ? VW'(0) : r_v + 1'b1;
    end else begin
      w_v_nxt = r_v;
    end
    w_x           = int'(r_h);
    w_y           = int'(r_v);
    w_in_pf       = (w_x >= ORG_X) && (w_x < PF_X1) && (w_y >= ORG_Y) && (w_y < PF_Y1);
    // With BORDER_PX=0 the ring collapses onto the playfield and is masked out.
    w_in_brd      = (w_x >= BR_X0) && (w_x < BR_X1) && (w_y >= BR_Y0) && (w_y < BR_Y1) && !w_in_pf;
    w_hs_raw      = !((w_x >= H_ACT + H_FP) && (w_x < H_ACT + H_FP + H_SYN));
    w_vs_raw      = !((w_y >= V_ACT + V_FP) && (w_y < V_ACT + V_FP + V_SYN));
    w_blank_n_raw = (w_x < H_ACT) && (w_y < V_ACT);
    w_fs_raw      = (w_x == 0) && (w_y == 0);
  end

  // S0: raster counters; tile sub-counters restart at the playfield origin
  // (and at line/frame wrap) so tile column/row never need a divider.
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      r_h    <= HW'(0);
      r_v    <= VW'(0);
      r_tcol <= HW'(0);
      r_tpx  <= TPW'(0);
      r_trow <= VW'(0);
      r_tpy  <= TPW'(0);
    end else begin
      r_h <= w_h_nxt;
      r_v <= w_v_nxt;
      if (w_h_end || (w_h_nxt == HW'(ORG_X))) begin
        r_tcol <= HW'(0);
        r_tpx  <= TPW'(0);
      end else if (r_tpx == TPW'(TILE_PX - 1)) begin
        r_tcol <= r_tcol + 1'b1;
        r_tpx  <= TPW'(0);
      end else begin
        r_tpx  <= r_tpx + 1'b1;
      end
      if (w_h_end) begin
        if (w_v_end || (w_v_nxt == VW'(ORG_Y))) begin
          r_trow <= VW'(0);
          r_tpy  <= TPW'(0);
        end else if (r_tpy == TPW'(TILE_PX - 1)) begin
          r_trow <= r_trow + 1'b1;
          r_tpy  <= TPW'(0);
        end else begin
          r_tpy  <= r_tpy + 1'b1;
        end
      end
    end
  end

  // S1: register tile coordinates, region flags and raw sync/blank
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      r_s1_tcol    <= HW'(0);
      r_s1_trow    <= VW'(0);
      r_s1_in_pf   <= 1'b0;
      r_s1_in_brd  <= 1'b0;
      r_s1_hs      <= 1'b1;
      r_s1_vs      <= 1'b1;
      r_s1_blank_n <= 1'b0;
      r_s1_fs      <= 1'b0;
    end else begin
      r_s1_tcol    <= r_tcol;
      r_s1_trow    <= r_trow;
      r_s1_in_pf   <= w_in_pf;
      r_s1_in_brd  <= w_in_brd;
      r_s1_hs      <= w_hs_raw;
      r_s1_vs      <= w_vs_raw;
      r_s1_blank_n <= w_blank_n_raw;
      r_s1_fs      <= w_fs_raw;
    end
  end

  // S2: cell read (pre-write value on a same-cycle write) and colour select
  always_comb begin
    w_idx_full = int'(r_s1_trow) * GRID_COLS + int'(r_s1_tcol);
    w_cell_idx = CIW'(w_idx_full);
    w_cell     = 2'b00;
    if (r_s1_in_pf && (w_idx_full < CELLS)) begin
      w_cell = r_cells[w_cell_idx];
    end else begin
      w_cell = 2'b00;
    end
    w_rgb = COL_BG;
    if (r_s1_in_pf) begin
      case (w_cell)
        2'b01:   w_rgb = COL_T1;
        2'b10:   w_rgb = COL_T2;
        2'b11:   w_rgb = COL_T3;
        default: w_rgb = COL_BG;
      endcase
    end else if (r_s1_in_brd) begin
      w_rgb = COL_BRD;
    end else begin
      w_rgb = COL_BG;
    end
  end

  // S2: registered outputs; colour forced to black outside active video
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      r_rgb     <= 24'h000000;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_fs      <= 1'b0;
    end else begin
      r_rgb     <= r_s1_blank_n ? w_rgb : 24'h000000;
      r_hs      <= r_s1_hs;
      r_vs      <= r_s1_vs;
      r_blank_n <= r_s1_blank_n;
      r_fs      <= r_s1_fs;
    end
  end

  // Clear sweep next-state: one cell per busy cycle, CELLS cycles in total
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    case (r_state)
      ST_IDLE: begin
        if (cpu_bus.iCLR_REQ) begin
          w_state_nxt = ST_SWEEP;
          w_k_nxt     = CIW'(0);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (r_k == CIW'(CELLS - 1)) begin
          w_state_nxt = ST_IDLE;
          w_k_nxt     = CIW'(0);
        end else begin
          w_k_nxt     = r_k + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_k_nxt     = CIW'(0);
      end
    endcase
  end

  // Clear sweep state register
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      r_state <= ST_IDLE;
      r_k     <= CIW'(0);
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // Processor write qualification (index range only; busy gating below)
  always_comb begin
    w_wr_ok  = (int'(cpu_bus.iWR_IDX) < CELLS);
    w_wr_idx = CIW'(cpu_bus.iWR_IDX);
  end

  // Cell array: the sweep owns the array while busy, processor writes otherwise
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < CELLS; i++) begin
        r_cells[i] <= 2'b00;
      end
    end else if (r_state == ST_SWEEP) begin
      r_cells[r_k] <= 2'b00;
    end else if (cpu_bus.iWR_EN && w_wr_ok) begin
      r_cells[w_wr_idx] <= cpu_bus.iWR_TYPE;
    end
  end

  assign cpu_bus.oCLR_BUSY = (r_state == ST_SWEEP);
  assign oFRAME_START      = r_fs;
  assign oHS               = r_hs;
  assign oVS               = r_vs;
  assign oBLANK_n          = r_blank_n;
  assign oR                = r_rgb[23:16];
  assign oG                = r_rgb[15:8];
  assign oB                = r_rgb[7:0];

endmodule
